muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
// Sequencer for MIPS MULT/MULTU/DIV/DIVU and owner of the architectural HI/LO registers.
// Sits beside the single-cycle ALU in EX: the decoder issues a one-cycle start with operands,
// and the block stalls the pipeline while multiply (1 step) or iterative divide (WIDTH steps) runs.
// Also services MTHI/MTLO writes and supports cancel on exception or flush.
// PARAMETERS
// WIDTH  32  operand/HI/LO width; the divider runs WIDTH iterations
// PORTS
// clk     in   1      clock, rising edge
// rst     in   1      synchronous reset, active-high
// start   in   1      issue strobe, sampled only in IDLE
// op      in   3      0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 = no-op
// a       in   WIDTH  rs operand (dividend/multiplicand; MTHI/MTLO data)
// b       in   WIDTH  rt operand (divisor/multiplier)
// cancel  in   1      abort current operation (exception/flush)
// stall   out  1      hold pipeline: combinational
// done    out  1      one-cycle pulse: HI/LO hold the new result
// hi      out  WIDTH  HI register
// lo      out  WIDTH  LO register
// BEHAVIOUR
// - Reset: state=IDLE; hi=0, lo=0, done=0, stall=0; internal counter/remainder/quotient cleared.
// - States: IDLE, MUL, DIV, DONE.
// - IDLE: start & op in {0,1} -> MUL; start & op in {2,3} & b!=0 -> DIV (latch |a|,|b|, signs, cnt=0).
//   start & op in {2,3} & b==0 -> DONE; hi<=a, lo<={WIDTH{1}} (divide-by-zero, no iteration).
//   start & op==4 -> hi<=a; op==5 -> lo<=a; stay IDLE, no stall, no done.
// - MUL: one cycle; {hi,lo} <= signed (op 0) or unsigned (op 1) 2*WIDTH product -> DONE.
// - DIV: one restoring step per cycle, cnt++; at cnt==WIDTH-1, write the result -> DONE.
//   Result: lo=quotient, hi=remainder. DIV signs: quotient negated if sign(a)^sign(b);
//   remainder takes sign of a. DIVU: no sign handling. 0x80000000/-1 gives lo=0x80000000, hi=0.
// - DONE: done=1 for exactly this cycle; hi/lo already updated; -> IDLE next edge.
// - stall = (state==IDLE & start & op in {0..3} & ~cancel) | state==MUL | state==DIV.
//   stall=0 in DONE, so the stalled instruction advances in the done cycle.
// - Latency from the start edge: MUL/MULTU done 1 cycle after acceptance (2nd cycle);
//   DIV/DIVU done in cycle WIDTH+1 (33 for WIDTH=32); divide-by-zero done in cycle 1.
// - Per-op mode latched at acceptance; a, b, op ignored after acceptance.
// - start outside IDLE is ignored (no queueing).
// - cancel (priority over all except rst): any state -> IDLE at the next edge, hi/lo keep old values,
//   no done pulse. cancel together with start in IDLE: the op is dropped, MTHI/MTLO included.
// - cancel in DONE: hi/lo were already written and stay; done still shows for that cycle.
// - rst mid-operation: everything returns to reset values at the next edge.
// - Back-to-back: a new start is accepted in the IDLE cycle after DONE; a start in DONE is ignored.
// TESTING
// - MULT a=-3 (0xFFFFFFFD), b=7 -> done in cycle 2; hi=0xFFFFFFFF, lo=0xFFFFFFEB; stall high cycles 0-1.
// - MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE.
// - DIV a=-7, b=2 -> done in cycle 33; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 100/7 -> lo=14, hi=2.
// - DIV a=5, b=0 -> done cycle 1, hi=5, lo=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
// - DIVU 100/7, assert cancel at cycle 10 -> IDLE next edge, stall=0, no done, hi/lo keep prior values;
//   start in MUL/DIV/DONE ignored.
// - MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 in consecutive cycles -> hi/lo updated, stall=0, done=0;
//   rst during DIV -> hi=lo=0, state IDLE.

Source files
------------

// File: rtl/muldiv_if.sv
// Issue/result bundle between the EX-stage decoder and the HI/LO sequencer.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, cancel, input stall, done, hi, lo);
  modport slave  (input start, op, a, b, cancel, output stall, done, hi, lo);
endinterface

// File: rtl/muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer and owner of the architectural HI/LO pair.
// Multiply takes one step, divide is a restoring divider running WIDTH steps.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ma, mb;     // latched multiply operands
  logic             msgn;       // signed multiply
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             neg_q, neg_r;

  // Magnitudes of the incoming operands for the signed divide.
  logic             div_s;
  logic [WIDTH-1:0] abs_a, abs_b;
  assign div_s = (bus.op == 3'd2);
  assign abs_a = (div_s && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign abs_b = (div_s && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // One multiplier serves both flavours: sign-extend for MULT, zero-extend for MULTU.
  logic [2*WIDTH-1:0] prod;
  assign prod = {{WIDTH{msgn & ma[WIDTH-1]}}, ma} * {{WIDTH{msgn & mb[WIDTH-1]}}, mb};

  // One restoring step: shift the next dividend bit in, subtract if it fits.
  logic [WIDTH:0]   rem_sh, diff;
  logic             ge;
  logic [WIDTH-1:0] rem_nx, quo_nx, q_fin, r_fin;
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs};
  assign ge     = ~diff[WIDTH];
  assign rem_nx = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nx = {quo[WIDTH-2:0], ge};
  assign q_fin  = neg_q ? -quo_nx : quo_nx;
  assign r_fin  = neg_r ? -rem_nx : rem_nx;

  // Stall the pipeline from the accepting cycle until the result cycle.
  assign bus.stall = (state == IDLE && bus.start && !bus.op[2] && !bus.cancel)
                   || state == MUL || state == DIV;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

  // Sequencer: cancel wins over everything but reset; hi/lo only change on completion or MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      cnt    <= '0;
      ma     <= '0;
      mb     <= '0;
      msgn   <= 1'b0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (bus.cancel) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          case (bus.op)
            3'd0, 3'd1: begin
              ma    <= bus.a;
              mb    <= bus.b;
              msgn  <= ~bus.op[0];
              state <= MUL;
            end
            3'd2, 3'd3: begin
              if (bus.b == '0) begin
                hi_q   <= bus.a;
                lo_q   <= '1;
                done_q <= 1'b1;
                state  <= DONE;
              end else begin
                quo   <= abs_a;
                dvs   <= abs_b;
                rem   <= '0;
                cnt   <= '0;
                neg_q <= div_s & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_r <= div_s & bus.a[WIDTH-1];
                state <= DIV;
              end
            end
            3'd4:    hi_q <= bus.a;
            3'd5:    lo_q <= bus.a;
            default: ;
          endcase
        end
        MUL: begin
          {hi_q, lo_q} <= prod;
          done_q       <= 1'b1;
          state        <= DONE;
        end
        DIV: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            hi_q   <= r_fin;
            lo_q   <= q_fin;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;  // DONE: result already visible, start here is ignored
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus pushes expected HI/LO and done cycle,
// a negedge monitor pops on every done pulse.
module tb_muldiv_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   pass = 0;
  int   total = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
  } exp_t;
  exp_t sbq[$];

  logic [W-1:0] mhi = '0, mlo = '0;  // reference HI/LO

  muldiv_if #(.WIDTH(W)) bus ();
  muldiv_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("hi", bus.hi, e.hi);
        chk("lo", bus.lo, e.lo);
        chk("done_cycle", cyc, e.cyc);
        chk("stall_in_done", bus.stall, 1'b0);
      end
    end
  end

  // Issue one op in the current cycle; on return we are #1 into the next cycle.
  // lat = cycles from issue to done (0 for ops that finish without a done pulse).
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat);
    longint       sa, sb, q, r;
    logic [63:0]  p;
    exp_t         e;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    lat = 0;
    case (o)
      3'd0: begin p = sa * sb; mhi = p[63:32]; mlo = p[31:0]; lat = 2; end
      3'd1: begin p = {32'b0, x} * {32'b0, y}; mhi = p[63:32]; mlo = p[31:0]; lat = 2; end
      3'd2, 3'd3: begin
        if (y == 0) begin mhi = x; mlo = '1; lat = 1; end
        else if (o == 3'd2) begin
          q = sa / sb; r = sa % sb;
          mlo = q[31:0]; mhi = r[31:0]; lat = W + 1;
        end else begin
          mlo = x / y; mhi = x % y; lat = W + 1;
        end
      end
      3'd4: mhi = x;
      3'd5: mlo = x;
      default: ;
    endcase
    if (lat > 0) begin
      e.hi = mhi; e.lo = mlo; e.cyc = cyc + lat;
      sbq.push_back(e);
    end
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    @(negedge clk);
    chk("stall_issue", bus.stall, (o < 3'd4));
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = $urandom_range(0, 7); bus.a = $urandom; bus.b = $urandom;
  endtask

  task automatic run(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int lat;
    issue(o, x, y, lat);
    repeat (lat) @(posedge clk);
    #1;
    chk("hi_after", bus.hi, mhi);
    chk("lo_after", bus.lo, mlo);
  endtask

  // A start that the DUT must ignore (or drop): no model update.
  task automatic stray_start(input logic [2:0] o, input logic [W-1:0] x, input logic c);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = 32'd3; bus.cancel = c;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.cancel = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.cancel = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_stall", bus.stall, 0);
    @(posedge clk); #1;

    // Directed cases
    run(3'd0, 32'hFFFFFFFD, 32'd7);
    run(3'd1, 32'hFFFFFFFF, 32'd2);
    run(3'd2, 32'hFFFFFFF9, 32'd2);
    run(3'd3, 32'd100, 32'd7);
    run(3'd2, 32'd5, 32'd0);
    run(3'd2, 32'h80000000, 32'hFFFFFFFF);
    run(3'd4, 32'h12345678, 32'd0);
    run(3'd5, 32'h9ABCDEF0, 32'd0);

    // Cancel DIVU mid-way: no done, hi/lo untouched.
    issue(3'd3, 32'd100, 32'd7, lat);
    repeat (8) @(posedge clk);
    #1 bus.cancel = 1'b1;
    @(negedge clk);
    chk("stall_div_cancel_cycle", bus.stall, 1'b1);
    @(posedge clk); #1 bus.cancel = 1'b0;
    void'(sbq.pop_back());
    {mhi, mlo} = {32'h12345678, 32'h9ABCDEF0};
    chk("cancel_stall", bus.stall, 0);
    chk("cancel_hi", bus.hi, mhi);
    chk("cancel_lo", bus.lo, mlo);
    repeat (40) @(posedge clk); #1;

    // Start with cancel in IDLE is dropped, MTHI included.
    stray_start(3'd4, 32'hCAFEF00D, 1'b1);
    chk("cancel_mthi_hi", bus.hi, mhi);

    // Starts during DIV and DONE are ignored.
    issue(3'd2, 32'd1000, 32'hFFFFFFFD, lat);
    repeat (4) @(posedge clk); #1;
    stray_start(3'd4, 32'hDEADBEEF, 1'b0);
    repeat (lat - 6) @(posedge clk); #1;   // now in the DONE cycle
    chk("in_done", bus.done, 1'b1);
    stray_start(3'd5, 32'hBAADF00D, 1'b0);
    chk("ignored_hi", bus.hi, mhi);
    chk("ignored_lo", bus.lo, mlo);
    chk("ignored_stall", bus.stall, 0);

    // Reset during DIV.
    issue(3'd3, 32'd77, 32'd5, lat);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sbq.delete();
    mhi = '0; mlo = '0;
    chk("rst_div_hi", bus.hi, 0);
    chk("rst_div_lo", bus.lo, 0);
    chk("rst_div_stall", bus.stall, 0);
    repeat (40) @(posedge clk); #1;

    // Randomized back-to-back traffic.
    for (int i = 0; i < 60; i++) begin
      logic [2:0]   o;
      logic [W-1:0] x, y;
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
      if ($urandom_range(0, 3) == 0) x = 32'h80000000;
      if ($urandom_range(0, 5) == 0) y = 32'hFFFFFFFF;
      run(o, x, y);
    end

    repeat (3) @(posedge clk); #1;
    chk("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
